// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision add/sub controller: unpack, align, add, normalize (external), round.
// Owns operand/result registers, the sticky alignment shifter, the magnitude adder and the RNE rounder.
module fp_add_seq_ctrl #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   op_a,
  input  logic [EXP_W+FRAC_W:0]   op_b,
  input  logic                    sub,
  output logic [FRAC_W+3:0]       nrm_sig,
  output logic                    nrm_carry,
  output logic [EXP_W-1:0]        nrm_exp,
  input  logic [FRAC_W+3:0]       nrm_sig_norm,
  input  logic [EXP_W-1:0]        nrm_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [3:0]              flags,
  output logic                    busy
);

  localparam int SIG_W = FRAC_W + 4;
  localparam int W     = EXP_W + FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;

  logic                   sign_a, sign_b, res_sign, zero_res, flush;
  logic [EXP_W-1:0]       exp_a, exp_b;
  logic [SIG_W-1:0]       sig_a, sig_b, sig_n;
  logic [EXP_W+1:0]       exp_n;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Unpack and special-operand detection on the live inputs
  logic                   fa_sign, fb_sign;
  logic [EXP_W-1:0]       fa_exp, fb_exp;
  logic [FRAC_W-1:0]      fa_frac, fb_frac;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign fa_sign = op_a[W-1];
  assign fb_sign = op_b[W-1] ^ sub;
  assign fa_exp  = op_a[W-2:FRAC_W];
  assign fb_exp  = op_b[W-2:FRAC_W];
  assign fa_frac = op_a[FRAC_W-1:0];
  assign fb_frac = op_b[FRAC_W-1:0];
  assign a_zero  = (fa_exp == '0) && (fa_frac == '0);
  assign b_zero  = (fb_exp == '0) && (fb_frac == '0);
  assign a_inf   = (fa_exp == EXP_MAX) && (fa_frac == '0);
  assign b_inf   = (fb_exp == EXP_MAX) && (fb_frac == '0);
  assign a_nan   = (fa_exp == EXP_MAX) && (fa_frac != '0);
  assign b_nan   = (fb_exp == EXP_MAX) && (fb_frac != '0);

  logic           is_special;
  logic [W-1:0]   sp_result;
  logic [3:0]     sp_flags;
  always_comb begin
    is_special = 1'b1;
    sp_result  = '0;
    sp_flags   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (fa_sign != fb_sign))) begin
      sp_result = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
      sp_flags  = 4'b1000;
    end else if (a_inf) begin
      sp_result = {fa_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      sp_result = {fb_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      sp_result = {fa_sign & fb_sign, {(W-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  // Alignment: larger magnitude goes to A, smaller is shifted right with sticky
  logic                   a_ge_b, big_sign, sml_sign;
  logic [EXP_W-1:0]       big_exp, sml_exp, d;
  logic [SIG_W-1:0]       big_sig, sml_sig, lost_mask, aligned;
  assign a_ge_b   = {exp_a, sig_a} >= {exp_b, sig_b};
  assign big_sign = a_ge_b ? sign_a : sign_b;
  assign sml_sign = a_ge_b ? sign_b : sign_a;
  assign big_exp  = a_ge_b ? exp_a  : exp_b;
  assign sml_exp  = a_ge_b ? exp_b  : exp_a;
  assign big_sig  = a_ge_b ? sig_a  : sig_b;
  assign sml_sig  = a_ge_b ? sig_b  : sig_a;
  assign d        = big_exp - sml_exp;

  always_comb begin
    lost_mask = '0;
    if (d >= EXP_W'(SIG_W)) begin
      aligned = {{(SIG_W-1){1'b0}}, |sml_sig};
    end else begin
      lost_mask = ~({SIG_W{1'b1}} << d);
      aligned   = (sml_sig >> d) | {{(SIG_W-1){1'b0}}, |(sml_sig & lost_mask)};
    end
  end

  logic [SIG_W:0]   sum;
  logic [SIG_W-1:0] diff;
  assign sum  = {1'b0, sig_a} + {1'b0, sig_b};
  assign diff = sig_a - sig_b;

  logic signed [EXP_W+1:0] exp_calc;
  assign exp_calc = $signed({2'b00, nrm_exp}) + $signed({{2{nrm_shift[EXP_W-1]}}, nrm_shift});

  // Round to nearest even on G/R/S; a carry out of the mantissa bumps the exponent
  logic                   g, r, s, lsb, inc, ovf;
  logic [FRAC_W+1:0]      mant_inc;
  logic [FRAC_W:0]        mant_r;
  logic [EXP_W+1:0]       exp_r;
  logic [EXP_W-1:0]       pack_exp;
  assign g        = sig_n[2];
  assign r        = sig_n[1];
  assign s        = sig_n[0];
  assign lsb      = sig_n[3];
  assign inc      = g & (r | s | lsb);
  assign mant_inc = {1'b0, sig_n[SIG_W-1:3]} + {{(FRAC_W+1){1'b0}}, inc};
  assign mant_r   = mant_inc[FRAC_W+1] ? {1'b1, {FRAC_W{1'b0}}} : mant_inc[FRAC_W:0];
  assign exp_r    = exp_n + {{(EXP_W+1){1'b0}}, mant_inc[FRAC_W+1]};
  assign ovf      = exp_r >= {2'b00, EXP_MAX};
  assign pack_exp = (!mant_r[FRAC_W] && (exp_r == {{(EXP_W+1){1'b0}}, 1'b1})) ? '0 : exp_r[EXP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      nrm_sig   <= '0;
      nrm_carry <= 1'b0;
      nrm_exp   <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      res_sign  <= 1'b0;
      zero_res  <= 1'b0;
      flush     <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
      sig_a     <= '0;
      sig_b     <= '0;
      sig_n     <= '0;
      exp_n     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_a <= fa_sign;
            sign_b <= fb_sign;
            exp_a  <= (fa_exp == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : fa_exp;
            exp_b  <= (fb_exp == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : fb_exp;
            sig_a  <= {fa_exp != '0, fa_frac, 3'b000};
            sig_b  <= {fb_exp != '0, fb_frac, 3'b000};
            if (is_special) begin
              result    <= sp_result;
              flags     <= sp_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          sign_a <= big_sign;
          sign_b <= sml_sign;
          exp_a  <= big_exp;
          sig_a  <= big_sig;
          sig_b  <= aligned;
          state  <= ADD;
        end
        ADD: begin
          nrm_exp <= exp_a;
          if (sign_a == sign_b) begin
            nrm_sig   <= sum[SIG_W-1:0];
            nrm_carry <= sum[SIG_W];
            zero_res  <= 1'b0;
            res_sign  <= sign_a;
          end else begin
            nrm_sig   <= diff;
            nrm_carry <= 1'b0;
            zero_res  <= (diff == '0);
            res_sign  <= (diff == '0) ? 1'b0 : sign_a;
          end
          state <= NORM;
        end
        NORM: begin
          sig_n <= nrm_sig_norm;
          exp_n <= exp_calc;
          flush <= exp_calc[EXP_W+1] || (exp_calc == '0);
          state <= ROUND;
        end
        ROUND: begin
          if (zero_res) begin
            result <= '0;
            flags  <= 4'b0000;
          end else if (flush) begin
            result <= {res_sign, {(W-1){1'b0}}};
            flags  <= 4'b0011;
          end else if (ovf) begin
            result <= {res_sign, EXP_MAX, {FRAC_W{1'b0}}};
            flags  <= 4'b0101;
          end else begin
            result <= {res_sign, pack_exp, mant_r[FRAC_W-1:0]};
            flags  <= {3'b000, g | r | s};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
